mnacidpro_seq_ctrl: RTL and testbench
=====================================

Name: mnacidpro_seq_ctrl

Overview:
- Digital sequencer for an N-stage chained nucleic-acid purification array (lysis/wash/elute source valves feeding cascaded stages).
- Generates every pneumatic control line: source valves, shared stage valves, a 3-phase peristaltic pump and per-stage collection valves.
- Runs one complete protocol per start: load, lysis, repeated wash, elute, then sequential per-stage collection.
- Successor to the fixed 3-stage hard-wired arrangement: stage count, timer width, pump rate and guard time are parametrised; wash repetition and elute pump reversal are new.

Parameters:
N_STAGES, 3, number of chained purification stages (1..16)
TIME_W, 16, width of phase-duration inputs and timer
PUMP_DIV, 4, clock cycles per pump pattern step (>=1)
GUARD_CYCLES, 2, all-closed settle cycles between phases (>=1)
REP_W, 4, width of wash repetition count

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  begin protocol; sampled only in IDLE
abort  in  1  terminate protocol; any state
load_time  in  TIME_W  LOAD phase cycles
lysis_time  in  TIME_W  LYSIS phase cycles
wash_time  in  TIME_W  cycles per WASH repetition
wash_reps  in  REP_W  WASH repetitions; 0 skips WASH
elute_time  in  TIME_W  ELUTE phase cycles
elute_rev  in  1  run pump in reverse during ELUTE
collect_time  in  TIME_W  cycles per stage collection
busy  out  1  protocol in progress
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort completion
phase  out  3  current state encoding (package enum)
stage_idx  out  $clog2(N_STAGES+1)  stage being collected
lysis_ctl, wash_ctl, elute_ctl  out  1 each  source valves
horiz_ctl, vertical_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, stage_wash_ctl  out  1 each  shared stage valves
collection_ctl  out  N_STAGES  per-stage collection valves
pump  out  3  peristaltic pump valves

Behaviour:
- Valve polarity: 1 = pressurised/closed; 0 = open. All outputs registered; changes appear the cycle after the state change.
- Reset: every *_ctl and collection_ctl all 1; pump = 3'b111; busy=0, done=0, aborted=0, phase=IDLE, stage_idx=0. rst mid-protocol returns to this state in one cycle, with no done or aborted pulse.
- States: IDLE, GUARD, LOAD, LYSIS, WASH, ELUTE, COLLECT, ABORT.
- IDLE + start (abort low): latch all time/rep/rev inputs, busy=1, enter GUARD then LOAD. Input changes after the latch are ignored.
- Between every pair of active phases: GUARD for GUARD_CYCLES cycles. During GUARD all valves closed and pump 3'b111, held.
- Timer: loads the latched duration, counts down, and exits the phase when it reaches 1. A duration of 0 is treated as 1 cycle.
- LOAD: horiz_ctl=0, bead_trap_ctl=0; pump forward.
- LYSIS: lysis_ctl=0, vertical_ctl=0, bead_trap_ctl=0; pump forward.
- WASH: wash_ctl=0, stage_wash_ctl=0, vertical_ctl=0, bead_trap_ctl=0; pump forward. Repeats wash_reps times, with a GUARD between repetitions. wash_reps=0 goes LYSIS→GUARD→ELUTE.
- ELUTE: elute_ctl=0, loop_exit_ctl=0, bead_vtl_ctl=0; pump forward, or reverse if elute_rev.
- COLLECT: collection_ctl[stage_idx]=0 (exactly one bit open), loop_exit_ctl=0; pump forward; lasts collect_time per stage.
  - After each stage: stage_idx increments, then GUARD.
  - After stage N_STAGES-1: done pulses, busy=0, stage_idx=0, IDLE.
- Invariant: at most one of lysis_ctl/wash_ctl/elute_ctl is 0 in any cycle. Collection_ctl is never 0 outside COLLECT.
- Pump:
  - Forward step sequence 3'b011→3'b101→3'b110→wrap; reverse runs the sequence backwards.
  - Advances every PUMP_DIV cycles while pumping; the divider restarts at each phase entry.
  - The first pattern on phase entry is 3'b011.
  - Pump halted (3'b111) in IDLE, GUARD and ABORT.
- Abort:
  - Any non-IDLE state + abort → ABORT: all closed for GUARD_CYCLES cycles, then aborted pulses, busy=0, IDLE.
  - Abort and start in the same IDLE cycle: start is ignored.
  - Abort in IDLE has no effect.
  - Abort on the final collect cycle takes priority over done.

Decomposition:
- Package mnacidpro_pkg: phase_e enum (IDLE..ABORT, 3 bits), VALVE_OPEN=1'b0, VALVE_CLOSED=1'b1, PUMP_HALT=3'b111, PUMP_SEQ[3] pattern constants.
- Sub-module mnacidpro_pump_seq (enable, reverse, restart → 3-bit pattern, PUMP_DIV parameter).
- Main FSM, timer and rep/stage counters remain in mnacidpro_seq_ctrl.

Test Plan:
- Reset: assert rst 3 cycles → all ctl=1, collection_ctl=3'b111, pump=3'b111, busy=0, phase=IDLE.
- Nominal run (N_STAGES=3, all times=5, wash_reps=2, PUMP_DIV=4, GUARD=2):
  - phase order LOAD,LYSIS,WASH,WASH,ELUTE,COLLECT×3;
  - done one pulse at cycle 1+2×8+5×8=57 after start (±1 per documented register stage);
  - collection_ctl bits 110,101,011 in order.
- wash_reps=0 and lysis_time=0 → WASH never entered; LYSIS lasts exactly 1 cycle.
- elute_rev=1 → during ELUTE pump steps 011,110,101 at 4-cycle spacing; other phases forward.
- abort during WASH → ABORT 2 cycles all closed, aborted pulse, no done, IDLE. A simultaneous start+abort in IDLE does nothing.
- Invariant checkers every cycle: one-hot-or-none on source valves, collection valves closed outside COLLECT, rst mid-ELUTE → reset values next cycle.

Source files
------------

// File: rtl/mnacidpro_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mnacidpro_pkg
// Brief    : Shared phase encoding, valve/pump constants and per-phase valve map
//            for the chained nucleic-acid purification sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package mnacidpro_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GUARD   = 3'd1,
        LOAD    = 3'd2,
        LYSIS   = 3'd3,
        WASH    = 3'd4,
        ELUTE   = 3'd5,
        COLLECT = 3'd6,
        ABORT   = 3'd7
    } phase_e;

    localparam logic VALVE_OPEN   = 1'b0;
    localparam logic VALVE_CLOSED = 1'b1;

    localparam logic [2:0]      PUMP_HALT = 3'b111;
    // Entry 0 is the first pattern after every phase entry.
    localparam logic [2:0][2:0] PUMP_SEQ  = {3'b110, 3'b101, 3'b011};

    typedef struct packed {
        logic lysis;
        logic wash;
        logic elute;
        logic horiz;
        logic vertical;
        logic loop_exit;
        logic bead_vtl;
        logic bead_trap;
        logic stage_wash;
    } valves_t;

    function automatic valves_t phase_valves(input phase_e p);
        valves_t v;
        v = '1;
        case (p)
            LOAD: begin
                v.horiz     = VALVE_OPEN;
                v.bead_trap = VALVE_OPEN;
            end
            LYSIS: begin
                v.lysis     = VALVE_OPEN;
                v.vertical  = VALVE_OPEN;
                v.bead_trap = VALVE_OPEN;
            end
            WASH: begin
                v.wash       = VALVE_OPEN;
                v.stage_wash = VALVE_OPEN;
                v.vertical   = VALVE_OPEN;
                v.bead_trap  = VALVE_OPEN;
            end
            ELUTE: begin
                v.elute     = VALVE_OPEN;
                v.loop_exit = VALVE_OPEN;
                v.bead_vtl  = VALVE_OPEN;
            end
            COLLECT: v.loop_exit = VALVE_OPEN;
            default: v = '1;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mnacidpro_pump_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mnacidpro_pump_seq
// Brief    : Three-phase peristaltic pump pattern generator with clock divider,
//            direction control and restart on phase entry.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mnacidpro_pump_seq #(
    parameter int PUMP_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       reverse,
    input  logic       restart,
    output logic [2:0] pattern
);
    import mnacidpro_pkg::*;

    localparam int              CNT_W      = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(PUMP_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [2:0]       r_pattern;
    logic [1:0]       w_idx_step;

    always_comb begin
        if (reverse) w_idx_step = (r_idx == 2'd0) ? 2'd2 : r_idx - 2'd1;
        else         w_idx_step = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_pattern <= PUMP_HALT;
        end else if (restart) begin
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_pattern <= PUMP_SEQ[0];
        end else if (r_cnt == C_DIV_LAST) begin
            r_cnt     <= '0;
            r_idx     <= w_idx_step;
            r_pattern <= PUMP_SEQ[w_idx_step];
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign pattern = r_pattern;

endmodule
`default_nettype wire

// File: rtl/mnacidpro_seq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mnacidpro_seq_ctrl
// Brief    : Protocol sequencer for an N-stage chained purification array:
//            load, lysis, repeated wash, elute, per-stage collection.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mnacidpro_seq_ctrl #(
    parameter int N_STAGES     = 3,
    parameter int TIME_W       = 16,
    parameter int PUMP_DIV     = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int REP_W        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [TIME_W-1:0]             load_time,
    input  logic [TIME_W-1:0]             lysis_time,
    input  logic [TIME_W-1:0]             wash_time,
    input  logic [REP_W-1:0]              wash_reps,
    input  logic [TIME_W-1:0]             elute_time,
    input  logic                          elute_rev,
    input  logic [TIME_W-1:0]             collect_time,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [2:0]                    phase,
    output logic [$clog2(N_STAGES+1)-1:0] stage_idx,
    output logic                          lysis_ctl,
    output logic                          wash_ctl,
    output logic                          elute_ctl,
    output logic                          horiz_ctl,
    output logic                          vertical_ctl,
    output logic                          loop_exit_ctl,
    output logic                          bead_vtl_ctl,
    output logic                          bead_trap_ctl,
    output logic                          stage_wash_ctl,
    output logic [N_STAGES-1:0]           collection_ctl,
    output logic [2:0]                    pump
);
    import mnacidpro_pkg::*;

    localparam int                STAGE_W      = $clog2(N_STAGES + 1);
    localparam logic [STAGE_W-1:0] C_LAST_STAGE = STAGE_W'(N_STAGES - 1);

    phase_e              r_state, r_after, w_next, w_after_n;
    logic [TIME_W-1:0]   r_timer, w_dur;
    logic [TIME_W-1:0]   r_load_t, r_lysis_t, r_wash_t, r_elute_t, r_collect_t;
    logic [REP_W-1:0]    r_reps, w_reps_n;
    logic [STAGE_W-1:0]  r_stage, w_stage_n;
    logic                r_elute_rev;
    logic                w_latch, w_done_n, w_aborted_n, w_timer_end;
    valves_t             r_valves;
    logic [N_STAGES-1:0] r_collection, w_collection;
    logic                r_busy, r_done, r_aborted;
    logic                w_pump_en, w_pump_rev, w_pump_restart;

    assign w_timer_end = (r_timer <= TIME_W'(1));

    always_comb begin
        w_next      = r_state;
        w_after_n   = r_after;
        w_reps_n    = r_reps;
        w_stage_n   = r_stage;
        w_latch     = 1'b0;
        w_done_n    = 1'b0;
        w_aborted_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_latch   = 1'b1;
                    w_next    = GUARD;
                    w_after_n = LOAD;
                    w_reps_n  = wash_reps;
                    w_stage_n = '0;
                end
            end
            ABORT: begin
                if (w_timer_end) begin
                    w_next      = IDLE;
                    w_aborted_n = 1'b1;
                    w_stage_n   = '0;
                end
            end
            default: begin
                if (abort) begin
                    w_next = ABORT;
                end else if (w_timer_end) begin
                    w_next = GUARD;
                    case (r_state)
                        GUARD:   w_next    = r_after;
                        LOAD:    w_after_n = LYSIS;
                        LYSIS:   w_after_n = (r_reps == '0) ? ELUTE : WASH;
                        WASH: begin
                            w_reps_n  = r_reps - REP_W'(1);
                            w_after_n = (r_reps <= REP_W'(1)) ? ELUTE : WASH;
                        end
                        ELUTE:   w_after_n = COLLECT;
                        COLLECT: begin
                            if (r_stage == C_LAST_STAGE) begin
                                w_next    = IDLE;
                                w_done_n  = 1'b1;
                                w_stage_n = '0;
                            end else begin
                                w_stage_n = r_stage + STAGE_W'(1);
                                w_after_n = COLLECT;
                            end
                        end
                        default: w_next = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Duration loaded into the timer on entry to the next state; 0 runs as 1.
    always_comb begin
        w_dur = TIME_W'(GUARD_CYCLES);
        case (w_next)
            LOAD:    w_dur = r_load_t;
            LYSIS:   w_dur = r_lysis_t;
            WASH:    w_dur = r_wash_t;
            ELUTE:   w_dur = r_elute_t;
            COLLECT: w_dur = r_collect_t;
            default: w_dur = TIME_W'(GUARD_CYCLES);
        endcase
        if (w_dur == '0) w_dur = TIME_W'(1);
    end

    always_comb begin
        w_collection = '1;
        for (int i = 0; i < N_STAGES; i++) begin
            if (w_next == COLLECT && w_stage_n == STAGE_W'(i)) w_collection[i] = VALVE_OPEN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_after      <= IDLE;
            r_timer      <= '0;
            r_load_t     <= '0;
            r_lysis_t    <= '0;
            r_wash_t     <= '0;
            r_elute_t    <= '0;
            r_collect_t  <= '0;
            r_elute_rev  <= 1'b0;
            r_reps       <= '0;
            r_stage      <= '0;
            r_valves     <= '1;
            r_collection <= '1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_after <= w_after_n;
            r_reps  <= w_reps_n;
            r_stage <= w_stage_n;
            if (w_next != r_state)        r_timer <= w_dur;
            else if (!w_timer_end)        r_timer <= r_timer - TIME_W'(1);
            if (w_latch) begin
                r_load_t    <= load_time;
                r_lysis_t   <= lysis_time;
                r_wash_t    <= wash_time;
                r_elute_t   <= elute_time;
                r_collect_t <= collect_time;
                r_elute_rev <= elute_rev;
            end
            r_valves     <= phase_valves(w_next);
            r_collection <= w_collection;
            r_busy       <= (w_next != IDLE);
            r_done       <= w_done_n;
            r_aborted    <= w_aborted_n;
        end
    end

    assign w_pump_en      = (w_next inside {LOAD, LYSIS, WASH, ELUTE, COLLECT});
    assign w_pump_rev     = (w_next == ELUTE) && r_elute_rev;
    assign w_pump_restart = (w_next != r_state);

    mnacidpro_pump_seq #(
        .PUMP_DIV (PUMP_DIV)
    ) u_pump (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_pump_en),
        .reverse (w_pump_rev),
        .restart (w_pump_restart),
        .pattern (pump)
    );

    assign busy           = r_busy;
    assign done           = r_done;
    assign aborted        = r_aborted;
    assign phase          = r_state;
    assign stage_idx      = r_stage;
    assign lysis_ctl      = r_valves.lysis;
    assign wash_ctl       = r_valves.wash;
    assign elute_ctl      = r_valves.elute;
    assign horiz_ctl      = r_valves.horiz;
    assign vertical_ctl   = r_valves.vertical;
    assign loop_exit_ctl  = r_valves.loop_exit;
    assign bead_vtl_ctl   = r_valves.bead_vtl;
    assign bead_trap_ctl  = r_valves.bead_trap;
    assign stage_wash_ctl = r_valves.stage_wash;
    assign collection_ctl = r_collection;

endmodule
`default_nettype wire

// File: tb/tb_mnacidpro_seq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mnacidpro_seq_ctrl
// Brief    : Self-checking bench for mnacidpro_seq_ctrl using a table of
//            protocol vectors plus directed multi-cycle corner sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mnacidpro_seq_ctrl;
    import mnacidpro_pkg::*;

    localparam int N_STAGES     = 3;
    localparam int TIME_W       = 16;
    localparam int PUMP_DIV     = 4;
    localparam int GUARD_CYCLES = 2;
    localparam int REP_W        = 4;
    localparam int STAGE_W      = $clog2(N_STAGES + 1);

    logic                clk = 1'b0;
    logic                rst, start, abort, elute_rev;
    logic [TIME_W-1:0]   load_time, lysis_time, wash_time, elute_time, collect_time;
    logic [REP_W-1:0]    wash_reps;
    logic                busy, done, aborted;
    logic [2:0]          phase;
    logic [STAGE_W-1:0]  stage_idx;
    logic                lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl;
    logic                loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, stage_wash_ctl;
    logic [N_STAGES-1:0] collection_ctl;
    logic [2:0]          pump;

    int checks = 0;
    int errors = 0;

    logic [2:0] load_pump[$];
    logic [2:0] elute_pump[$];
    logic [2:0] collect_first;

    mnacidpro_seq_ctrl #(
        .N_STAGES(N_STAGES), .TIME_W(TIME_W), .PUMP_DIV(PUMP_DIV),
        .GUARD_CYCLES(GUARD_CYCLES), .REP_W(REP_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .load_time(load_time), .lysis_time(lysis_time), .wash_time(wash_time),
        .wash_reps(wash_reps), .elute_time(elute_time), .elute_rev(elute_rev),
        .collect_time(collect_time), .busy(busy), .done(done), .aborted(aborted),
        .phase(phase), .stage_idx(stage_idx), .lysis_ctl(lysis_ctl),
        .wash_ctl(wash_ctl), .elute_ctl(elute_ctl), .horiz_ctl(horiz_ctl),
        .vertical_ctl(vertical_ctl), .loop_exit_ctl(loop_exit_ctl),
        .bead_vtl_ctl(bead_vtl_ctl), .bead_trap_ctl(bead_trap_ctl),
        .stage_wash_ctl(stage_wash_ctl), .collection_ctl(collection_ctl), .pump(pump)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [TIME_W-1:0] load_t, lysis_t, wash_t, elute_t, collect_t;
        logic [REP_W-1:0]  reps;
        logic              rev;
        int                abort_at;
        int                exp_end;
        logic              exp_done;
        int                exp_wash;
        int                exp_lysis;
        int                exp_abort_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Valve bundle order: lysis,wash,elute,horiz,vertical,loop_exit,bead_vtl,bead_trap,stage_wash
    function automatic logic [8:0] exp_ctl(input logic [2:0] p);
        case (p)
            3'd2:    return 9'b111011101;
            3'd3:    return 9'b011101101;
            3'd4:    return 9'b101101100;
            3'd5:    return 9'b110110011;
            3'd6:    return 9'b111110111;
            default: return 9'b111111111;
        endcase
    endfunction

    task automatic invariants();
        logic [8:0] ctl;
        int n_src;
        ctl   = {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
                 loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, stage_wash_ctl};
        n_src = int'(!lysis_ctl) + int'(!wash_ctl) + int'(!elute_ctl);
        check("src_onehot", 32'(n_src <= 1), 32'd1);
        check("phase_valves", 32'(ctl), 32'(exp_ctl(phase)));
        if (phase == COLLECT) begin
            check("coll_one_open", 32'($countones(~collection_ctl)), 32'd1);
            check("coll_at_stage", 32'(collection_ctl[stage_idx]), 32'd0);
        end else begin
            check("coll_closed", 32'(collection_ctl), 32'(3'b111));
        end
        if (phase == IDLE || phase == GUARD || phase == ABORT)
            check("pump_halt", 32'(pump), 32'(3'b111));
        else
            check("pump_valid", 32'(pump == 3'b011 || pump == 3'b101 || pump == 3'b110), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int wash_entries = 0, lysis_cyc = 0, abort_cyc = 0, end_k = -1;
        logic saw_done = 1'b0, saw_abort = 1'b0, first_coll = 1'b1;
        logic [2:0] prev_phase;
        logic [N_STAGES-1:0] coll_seq[$];
        logic [N_STAGES-1:0] exp_c, act_c;
        load_pump.delete();
        elute_pump.delete();
        collect_first = 3'b000;
        load_time = v.load_t; lysis_time = v.lysis_t; wash_time = v.wash_t;
        elute_time = v.elute_t; collect_time = v.collect_t; wash_reps = v.reps;
        elute_rev = v.rev; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Later input changes must not disturb the latched protocol.
        load_time = 16'd40; lysis_time = 16'd0; wash_time = 16'd33; wash_reps = 4'd9;
        elute_time = 16'd2; elute_rev = ~v.rev; collect_time = 16'd50;
        prev_phase = phase;
        for (int k = 1; k <= 200; k++) begin
            abort = (k == v.abort_at);
            @(posedge clk); #1;
            invariants();
            if (phase == LYSIS) lysis_cyc++;
            if (phase == ABORT) abort_cyc++;
            if (phase == WASH && prev_phase != WASH) wash_entries++;
            if (phase == LOAD)  load_pump.push_back(pump);
            if (phase == ELUTE) elute_pump.push_back(pump);
            if (phase == COLLECT && first_coll) begin
                collect_first = pump;
                first_coll = 1'b0;
            end
            if (phase == COLLECT && (coll_seq.size() == 0 || coll_seq[coll_seq.size()-1] != collection_ctl))
                coll_seq.push_back(collection_ctl);
            prev_phase = phase;
            if (done || aborted) begin
                end_k = k; saw_done = done; saw_abort = aborted;
                break;
            end
        end
        abort = 1'b0;
        check({v.name, " end_cycle"}, 32'(end_k), 32'(v.exp_end));
        check({v.name, " done"}, 32'(saw_done), 32'(v.exp_done));
        check({v.name, " aborted"}, 32'(saw_abort), 32'(!v.exp_done));
        check({v.name, " wash_entries"}, 32'(wash_entries), 32'(v.exp_wash));
        check({v.name, " lysis_cycles"}, 32'(lysis_cyc), 32'(v.exp_lysis));
        check({v.name, " abort_cycles"}, 32'(abort_cyc), 32'(v.exp_abort_cyc));
        check({v.name, " busy_end"}, 32'(busy), 32'd0);
        check({v.name, " phase_end"}, 32'(phase), 32'(IDLE));
        check({v.name, " stage_end"}, 32'(stage_idx), 32'd0);
        if (v.exp_done) begin
            check({v.name, " coll_count"}, 32'(coll_seq.size()), 32'(N_STAGES));
            for (int i = 0; i < N_STAGES; i++) begin
                exp_c = '1;
                exp_c[i] = 1'b0;
                act_c = (i < coll_seq.size()) ? coll_seq[i] : '0;
                check({v.name, " coll_order"}, 32'(act_c), 32'(exp_c));
            end
        end
        @(posedge clk); #1;
        check({v.name, " pulse_width"}, 32'(done | aborted), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   wait_k;
        logic any_pulse;
        logic [2:0] exp_rev[3];
        vecs[0] = '{"nominal",  16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 4'd2, 1'b0, 0,  56, 1'b1, 2, 5, 0};
        vecs[1] = '{"no_wash",  16'd5, 16'd0, 16'd5, 16'd5, 16'd5, 4'd0, 1'b0, 0,  38, 1'b1, 0, 1, 0};
        vecs[2] = '{"mixed",    16'd3, 16'd2, 16'd4, 16'd6, 16'd1, 4'd1, 1'b0, 0,  32, 1'b1, 1, 2, 0};
        vecs[3] = '{"min_time", 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 4'd3, 1'b0, 0,  27, 1'b1, 3, 1, 0};
        vecs[4] = '{"abort_wash", 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 4'd2, 1'b0, 18, 20, 1'b0, 1, 5, 2};

        rst = 1'b1; start = 1'b0; abort = 1'b0; elute_rev = 1'b0;
        load_time = '0; lysis_time = '0; wash_time = '0; elute_time = '0;
        collect_time = '0; wash_reps = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst ctl", 32'({lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
                              loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, stage_wash_ctl}), 32'h1FF);
        check("rst collection", 32'(collection_ctl), 32'(3'b111));
        check("rst pump", 32'(pump), 32'(3'b111));
        check("rst busy", 32'(busy), 32'd0);
        check("rst pulses", 32'({done, aborted}), 32'd0);
        check("rst phase", 32'(phase), 32'(IDLE));
        check("rst stage", 32'(stage_idx), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reverse elute: 4-cycle steps 011,110,101; LOAD stays forward.
        rv = '{"reverse", 16'd5, 16'd1, 16'd5, 16'd12, 16'd1, 4'd0, 1'b1, 0, 33, 1'b1, 0, 1, 0};
        run_vec(rv);
        exp_rev[0] = 3'b011; exp_rev[1] = 3'b110; exp_rev[2] = 3'b101;
        check("rev elute_len", 32'(elute_pump.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            check("rev elute_pump", 32'((i < elute_pump.size()) ? elute_pump[i] : 3'b000), 32'(exp_rev[i/4]));
        check("fwd load_len", 32'(load_pump.size()), 32'd5);
        check("fwd load_first", 32'((load_pump.size() > 0) ? load_pump[0] : 3'b000), 32'(3'b011));
        check("fwd load_step", 32'((load_pump.size() > 4) ? load_pump[4] : 3'b000), 32'(3'b101));
        check("fwd collect_first", 32'(collect_first), 32'(3'b011));

        // Start with abort in the same IDLE cycle, then abort alone in IDLE.
        load_time = 16'd5; lysis_time = 16'd5; wash_time = 16'd5; wash_reps = 4'd2;
        elute_time = 16'd5; collect_time = 16'd5; elute_rev = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort phase", 32'(phase), 32'(IDLE));
        check("start_abort busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("start_abort later", 32'({busy, phase}), 32'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort", 32'({busy, aborted, phase}), 32'd0);

        // Reset in the middle of ELUTE.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_k = 0;
        while (phase != ELUTE && wait_k < 100) begin
            @(posedge clk); #1;
            wait_k++;
        end
        check("reach_elute", 32'(phase), 32'(ELUTE));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst ctl", 32'({lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
                                  loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, stage_wash_ctl}), 32'h1FF);
        check("mid_rst collection", 32'(collection_ctl), 32'(3'b111));
        check("mid_rst pump", 32'(pump), 32'(3'b111));
        check("mid_rst state", 32'({busy, phase, stage_idx}), 32'd0);
        any_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            any_pulse |= done | aborted | busy;
        end
        check("mid_rst no_pulse", 32'(any_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
